// File: rtl/mips_mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Holds the state enum, opcode constants, the datapath mux/ALU encodings,
// trap cause codes and the bundled control-strobe struct.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    RWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_ONE  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_ALUOUT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       beq;
    logic       bne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_wait_timer.sv
// Memory-wait counter for the multicycle controller.
// Ports: clk/rst (sync, active high), clear (restart at 0), enable (count one
// wait cycle), expired (count sits at TIMEOUT-1; never set when TIMEOUT=0).
// The counter saturates at all-ones so a disabled timeout cannot wrap.
module mc_wait_timer #(
  parameter int TIMEOUT   = 15,
  parameter int TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT =
    TIMEOUT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable && (count != '1))
      count <= count + 1'b1;
  end

  assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller with a mem_ready handshake.
// Inputs: clk, rst (sync, active high), opcode (IR[31:26]), mem_ready.
// Outputs: every datapath strobe/mux select, a sticky trap flag with cause,
// and the current state for debug. All outputs read 0 while rst is high.
module mips_mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT   = 15,
  parameter int TIMEOUT_W = 4,
  parameter int HAS_BNE   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       BeQ,
  output logic       BnE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSrc,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_o
);

  state_t     state, next;
  logic [1:0] cause_q, next_cause;
  ctrl_t      c, c_out;
  logic       expired, wait_st;

  assign wait_st = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

  // Any state change restarts the count, which covers "cleared on entry".
  mc_wait_timer #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(TIMEOUT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (next != state),
    .enable  (wait_st && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cause_q <= CAUSE_NONE;
    else if ((next == TRAP) && (state != TRAP))
      cause_q <= next_cause;
  end

  always_comb begin
    next       = state;
    next_cause = CAUSE_NONE;
    case (state)
      // mem_ready in the limit cycle wins over the timeout.
      FETCH, MEMRD, MEMWR: begin
        if (mem_ready) begin
          if (state == FETCH)      next = DECODE;
          else if (state == MEMRD) next = MEMWB;
          else                     next = FETCH;
        end else if (expired) begin
          next       = TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        case (opcode)
          OP_R:         next = EXEC;
          OP_LW, OP_SW: next = MEMADR;
          OP_BEQ:       next = BRANCH;
          OP_BNE: begin
            if (HAS_BNE != 0) next = BRANCH;
            else begin
              next       = TRAP;
              next_cause = CAUSE_ILLEGAL;
            end
          end
          OP_ADDI:      next = ADDIEX;
          OP_J:         next = JUMP;
          default: begin
            next       = TRAP;
            next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      MEMADR:  next = (opcode == OP_SW) ? MEMWR : MEMRD;
      EXEC:    next = RWB;
      ADDIEX:  next = ADDIWB;
      TRAP:    next = TRAP;
      default: next = FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    case (state)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_ONE;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      DECODE: c.alu_src_b = SRCB_IMM;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PC_ALUOUT;
        c.beq       = (opcode == OP_BEQ);
        c.bne       = (opcode == OP_BNE);
      end
      ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      ADDIWB: c.reg_write = 1'b1;
      JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_JUMP;
      end
      default: c = '0;
    endcase
  end

  // Reset masks every output so nothing is written during the reset cycle.
  assign c_out      = rst ? '0 : c;
  assign PCWrite    = c_out.pc_write;
  assign BeQ        = c_out.beq;
  assign BnE        = c_out.bne;
  assign IorD       = c_out.iord;
  assign MemRead    = c_out.mem_read;
  assign MemWrite   = c_out.mem_write;
  assign IRWrite    = c_out.ir_write;
  assign RegWrite   = c_out.reg_write;
  assign RegDst     = c_out.reg_dst;
  assign MemToReg   = c_out.mem_to_reg;
  assign ALUSrcA    = c_out.alu_src_a;
  assign ALUSrcB    = c_out.alu_src_b;
  assign ALUop      = c_out.alu_op;
  assign PCSrc      = c_out.pc_src;
  assign trap       = !rst && (state == TRAP);
  assign trap_cause = (!rst && (state == TRAP)) ? cause_q : CAUSE_NONE;
  assign state_o    = rst ? 4'd0 : state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench: the stimulus walks each instruction through its phase
// recipe, pushes the expected control vector for every cycle, and a negedge
// monitor pops and compares against the DUT.
module tb_mips_mc_ctrl;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_EXEC = 6, S_RWB = 7,
                 S_BRANCH = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11,
                 S_TRAP = 12;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, BNE = 6'b000101,
                         ADDI = 6'b001000, J = 6'b000010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = '0;
  logic mem_ready = 1'b0;

  logic pcw0, beq0, bne0, iord0, mrd0, mwr0, irw0, rgw0, rdst0, m2r0, asa0, tr0;
  logic [1:0] asb0, aop0, pcs0, tc0;
  logic [3:0] st0;
  logic pcw1, beq1, bne1, iord1, mrd1, mwr1, irw1, rgw1, rdst1, m2r1, asa1, tr1;
  logic [1:0] asb1, aop1, pcs1, tc1;
  logic [3:0] st1;

  mips_mc_ctrl #(.TIMEOUT(15), .TIMEOUT_W(4), .HAS_BNE(1)) u0 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw0), .BeQ(beq0), .BnE(bne0), .IorD(iord0), .MemRead(mrd0),
    .MemWrite(mwr0), .IRWrite(irw0), .RegWrite(rgw0), .RegDst(rdst0),
    .MemToReg(m2r0), .ALUSrcA(asa0), .ALUSrcB(asb0), .ALUop(aop0),
    .PCSrc(pcs0), .trap(tr0), .trap_cause(tc0), .state_o(st0));

  mips_mc_ctrl #(.TIMEOUT(15), .TIMEOUT_W(4), .HAS_BNE(0)) u1 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(pcw1), .BeQ(beq1), .BnE(bne1), .IorD(iord1), .MemRead(mrd1),
    .MemWrite(mwr1), .IRWrite(irw1), .RegWrite(rgw1), .RegDst(rdst1),
    .MemToReg(m2r1), .ALUSrcA(asa1), .ALUSrcB(asb1), .ALUop(aop1),
    .PCSrc(pcs1), .trap(tr1), .trap_cause(tc1), .state_o(st1));

  always #5 clk = ~clk;

  int chk_cnt = 0, pass_cnt = 0;
  logic [23:0] expq[$];
  logic [1:0] m_cause = 2'b00;

  // Expected control vector for a state, straight from the per-state table.
  function automatic logic [23:0] exp_vec(int st, logic [5:0] op, bit mr);
    logic pcw, beq, bne, iord, mrd, mwr, irw, rgw, rdst, m2r, asa, tr;
    logic [1:0] asb, aop, pcs, cs;
    {pcw, beq, bne, iord, mrd, mwr, irw, rgw, rdst, m2r, asa, tr} = '0;
    {asb, aop, pcs, cs} = '0;
    case (st)
      S_FETCH:  begin mrd = 1; asb = 2'b10; irw = mr; pcw = mr; end
      S_DECODE: asb = 2'b01;
      S_MEMADR: begin asa = 1; asb = 2'b01; end
      S_MEMRD:  begin mrd = 1; iord = 1; end
      S_MEMWB:  begin rgw = 1; m2r = 1; end
      S_MEMWR:  begin mwr = 1; iord = 1; end
      S_EXEC:   begin asa = 1; aop = 2'b10; end
      S_RWB:    begin rgw = 1; rdst = 1; end
      S_BRANCH: begin asa = 1; aop = 2'b01; pcs = 2'b10;
                      beq = (op == BEQ); bne = (op == BNE); end
      S_ADDIEX: begin asa = 1; asb = 2'b01; end
      S_ADDIWB: rgw = 1;
      S_JUMP:   begin pcw = 1; pcs = 2'b01; end
      S_TRAP:   begin tr = 1; cs = m_cause; end
      default:  ;
    endcase
    return {pcw, beq, bne, iord, mrd, mwr, irw, rgw, rdst, m2r, asa,
            asb, aop, pcs, tr, cs, 4'(st)};
  endfunction

  // One clock: drive inputs just after the edge and queue the expectation.
  task automatic cyc(input bit r, input bit mr, input logic [5:0] op, input int st);
    @(posedge clk); #1;
    rst = r; mem_ready = mr; opcode = op;
    expq.push_back(r ? 24'd0 : exp_vec(st, op, mr));
  endtask

  task automatic do_trap(input logic [1:0] cause);
    m_cause = cause;
    repeat (2) cyc(0, 1'($urandom), 6'($urandom), S_TRAP);
    cyc(1, 1'b1, 6'd0, S_FETCH);
    m_cause = 2'b00;
  endtask

  // Memory wait phase: ready arrives after w idle cycles; the 15th idle
  // cycle in a row traps instead.
  task automatic wait_phase(input int st, input logic [5:0] op, input int w,
                            output bit trapped);
    trapped = 0;
    for (int k = 0; ; k++) begin
      cyc(0, k >= w, op, st);
      if (k >= w) break;
      if (k == 14) begin trapped = 1; break; end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    bit t;
    wait_phase(S_FETCH, op, fw, t);
    if (t) begin do_trap(2'b10); return; end
    cyc(0, 1'($urandom), op, S_DECODE);
    case (op)
      R:    begin cyc(0, 1'($urandom), op, S_EXEC); cyc(0, 1'($urandom), op, S_RWB); end
      LW:   begin
        cyc(0, 1'($urandom), op, S_MEMADR);
        wait_phase(S_MEMRD, op, mw, t);
        if (t) do_trap(2'b10); else cyc(0, 1'($urandom), op, S_MEMWB);
      end
      SW:   begin
        cyc(0, 1'($urandom), op, S_MEMADR);
        wait_phase(S_MEMWR, op, mw, t);
        if (t) do_trap(2'b10);
      end
      BEQ, BNE: cyc(0, 1'($urandom), op, S_BRANCH);
      ADDI: begin cyc(0, 1'($urandom), op, S_ADDIEX); cyc(0, 1'($urandom), op, S_ADDIWB); end
      J:    cyc(0, 1'($urandom), op, S_JUMP);
      default: do_trap(2'b01);
    endcase
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s act=%h exp=%h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      logic [23:0] e, a;
      e = expq.pop_front();
      a = {pcw0, beq0, bne0, iord0, mrd0, mwr0, irw0, rgw0, rdst0, m2r0, asa0,
           asb0, aop0, pcs0, tr0, tc0, st0};
      chk_cnt++;
      if (a === e) pass_cnt++;
      else $display("FAIL ctrl_vec t=%0t act=%h exp=%h", $time, a, e);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal[7];
    logic [5:0] op;
    int fw, mw;
    legal = '{R, LW, SW, BEQ, BNE, ADDI, J};
    repeat (2) @(posedge clk);
    cyc(1, 1'b1, 6'd0, S_FETCH);
    cyc(1, 1'b0, 6'd0, S_FETCH);

    // Zero-wait program.
    run_instr(LW, 0, 0); run_instr(ADDI, 0, 0); run_instr(R, 0, 0);
    run_instr(SW, 0, 0); run_instr(BEQ, 0, 0); run_instr(J, 0, 0);
    // Fetch with three wait cycles.
    run_instr(R, 3, 0);
    // MEMRD ready in the limit cycle, then a full timeout.
    run_instr(LW, 0, 14);
    run_instr(LW, 0, 15);
    run_instr(SW, 2, 16);
    // Illegal opcode.
    run_instr(6'b111111, 0, 0);

    // bne with HAS_BNE=0 traps on the second instance.
    run_instr(BNE, 0, 0);
    @(negedge clk); #1;
    check("u1_bne_state", {4'd0, st1}, 8'd12);
    check("u1_bne_trap", {7'd0, tr1}, 8'd1);
    check("u1_bne_cause", {6'd0, tc1}, 8'd1);
    check("u1_bne_memread", {7'd0, mrd1}, 8'd0);

    // Reset during MEMWR with ready: no write, restart at FETCH.
    cyc(0, 1'b1, SW, S_FETCH);
    cyc(0, 1'b0, SW, S_DECODE);
    cyc(0, 1'b1, SW, S_MEMADR);
    cyc(1, 1'b1, SW, S_MEMWR);
    run_instr(ADDI, 0, 0);

    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 99);
      op = (r < 8) ? 6'($urandom) : legal[$urandom_range(0, 6)];
      r = $urandom_range(0, 99);
      fw = (r < 70) ? 0 : (r < 92) ? $urandom_range(1, 4) : $urandom_range(12, 16);
      r = $urandom_range(0, 99);
      mw = (r < 60) ? 0 : (r < 90) ? $urandom_range(1, 5) : $urandom_range(13, 16);
      run_instr(op, fw, mw);
    end

    @(negedge clk); #1;
    check("queue_drained", 8'(expq.size()), 8'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
